// File: rtl/common_pkg.sv
// Shared types for the systolic-array datapath: PE data words, drain channel
// records and the tagged results that leave the drain collector.
package common_pkg;

  localparam int DATA_WIDTH    = 32;
  localparam int ARRAY_DIM     = 4;
  localparam int COL_IDX_WIDTH = $clog2(ARRAY_DIM);

  typedef logic [DATA_WIDTH-1:0] data_t;

  typedef struct packed {
    data_t data;
    logic  enable;
  } drain_data_t;

  typedef struct packed {
    data_t                    data;
    logic [COL_IDX_WIDTH-1:0] col;
  } drain_result_t;

endpackage

// File: rtl/drain_collector_fifo.sv
// Synchronous FIFO of tagged drain results with a combinational head.
// Pointers wrap naturally because DEPTH is a power of two.
module result_fifo
  import common_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       push_i,
  input  drain_result_t              push_data_i,
  input  logic                       pop_i,
  output drain_result_t              head_o,
  output logic                       full_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  drain_result_t      mem_q [DEPTH];
  drain_result_t      mem_d [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               do_push;
  logic               do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  // A push into a full FIFO is only legal when a pop frees the head slot.
  assign do_pop  = pop_i && (count_q != '0);
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data_i;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/drain_collector.sv
// Collects one-cycle drain pulses from a PE row, arbitrates lowest column first
// and streams {data, col, last} results out through a small FIFO.
module drain_collector
  import common_pkg::*;
#(
  parameter int NUM_PE     = ARRAY_DIM,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  drain_data_t [NUM_PE-1:0] drain_i,
  output logic                     res_valid_o,
  input  logic                     res_ready_i,
  output data_t                    res_data_o,
  output logic [COL_IDX_WIDTH-1:0] res_col_o,
  output logic                     res_last_o,
  output logic                     overflow_o
);

  logic [NUM_PE-1:0]              slot_valid_q, slot_valid_d;
  data_t                          slot_data_q [NUM_PE];
  data_t                          slot_data_d [NUM_PE];
  logic                           overflow_q, overflow_d;

  logic                           cand_valid;
  logic [COL_IDX_WIDTH-1:0]       cand_idx;
  logic [NUM_PE-1:0]              pushed_vec;
  logic                           push;
  logic                           pop;
  logic                           fifo_full;
  logic [$clog2(FIFO_DEPTH):0]    fifo_count;
  drain_result_t                  push_data;
  drain_result_t                  head;

  assign res_valid_o = (fifo_count != '0);
  assign pop         = res_valid_o && res_ready_i;
  assign push        = cand_valid && (!fifo_full || pop);
  assign push_data   = '{data: slot_data_q[cand_idx], col: cand_idx};

  // Scanning from the top down leaves the lowest valid column as the winner.
  always_comb begin
    cand_valid = 1'b0;
    cand_idx   = '0;
    for (int c = NUM_PE - 1; c >= 0; c--) begin
      if (slot_valid_q[c]) begin
        cand_valid = 1'b1;
        cand_idx   = COL_IDX_WIDTH'(c);
      end
    end
  end

  always_comb begin
    pushed_vec = '0;
    if (push) begin
      pushed_vec[cand_idx] = 1'b1;
    end
  end

  // A slot leaving this cycle may be refilled; a busy slot drops the new pulse.
  always_comb begin
    slot_valid_d = slot_valid_q;
    slot_data_d  = slot_data_q;
    overflow_d   = overflow_q;
    for (int c = 0; c < NUM_PE; c++) begin
      if (drain_i[c].enable) begin
        if (!slot_valid_q[c] || pushed_vec[c]) begin
          slot_valid_d[c] = 1'b1;
          slot_data_d[c]  = drain_i[c].data;
        end else begin
          overflow_d = 1'b1;
        end
      end else if (pushed_vec[c]) begin
        slot_valid_d[c] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      slot_valid_q <= '0;
      slot_data_q  <= '{default: '0};
      overflow_q   <= 1'b0;
    end else begin
      slot_valid_q <= slot_valid_d;
      slot_data_q  <= slot_data_d;
      overflow_q   <= overflow_d;
    end
  end

  result_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (push),
    .push_data_i (push_data),
    .pop_i       (pop),
    .head_o      (head),
    .full_o      (fifo_full),
    .count_o     (fifo_count)
  );

  assign res_data_o = head.data;
  assign res_col_o  = head.col;
  assign res_last_o = (head.col == COL_IDX_WIDTH'(NUM_PE - 1));
  assign overflow_o = overflow_q;

endmodule

// File: tb/tb_drain_collector.sv
// Directed bench for drain_collector: single pulse, skewed row, simultaneous
// pulses, backpressure, pending collision and mid-stream reset.
module tb_drain_collector;
  import common_pkg::*;

  logic                     clk_i = 1'b0;
  logic                     rst_i;
  drain_data_t [3:0]        drain;
  logic                     res_valid_o;
  logic                     res_ready_i;
  data_t                    res_data_o;
  logic [COL_IDX_WIDTH-1:0] res_col_o;
  logic                     res_last_o;
  logic                     overflow_o;

  int total = 0;
  int bad   = 0;

  always #5 clk_i = ~clk_i;

  drain_collector #(
    .NUM_PE     (4),
    .FIFO_DEPTH (8)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .drain_i     (drain),
    .res_valid_o (res_valid_o),
    .res_ready_i (res_ready_i),
    .res_data_o  (res_data_o),
    .res_col_o   (res_col_o),
    .res_last_o  (res_last_o),
    .overflow_o  (overflow_o)
  );

  // Advance one edge and settle just after it; inputs change and outputs are sampled here.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic applyStimulus(input int col, input logic [31:0] data);
    drain[col].data   = data;
    drain[col].enable = 1'b1;
  endtask

  task automatic clearDrain();
    drain = '0;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkHead(input string tag, input logic [31:0] data, input int col, input logic last);
    checkOutput({tag, "_valid"}, 32'(res_valid_o), 32'd1);
    checkOutput({tag, "_data"}, res_data_o, data);
    checkOutput({tag, "_col"}, 32'(res_col_o), 32'(col));
    checkOutput({tag, "_last"}, 32'(res_last_o), 32'(last));
  endtask

  initial begin
    rst_i       = 1'b1;
    res_ready_i = 1'b0;
    drain       = '0;
    tick();
    tick();
    checkOutput("rst_valid", 32'(res_valid_o), 32'd0);
    checkOutput("rst_data", res_data_o, 32'd0);
    checkOutput("rst_col", 32'(res_col_o), 32'd0);
    checkOutput("rst_last", 32'(res_last_o), 32'd0);
    checkOutput("rst_ovf", 32'(overflow_o), 32'd0);
    rst_i = 1'b0;
    tick();

    // Single pulse: slot cycle, then head, then popped.
    res_ready_i = 1'b1;
    applyStimulus(2, 32'h0000_0015);
    tick();
    clearDrain();
    checkOutput("single_slot_only", 32'(res_valid_o), 32'd0);
    tick();
    checkHead("single", 32'h15, 2, 1'b0);
    tick();
    checkOutput("single_popped", 32'(res_valid_o), 32'd0);

    // Skewed row: one column per cycle, streamed out one per cycle.
    for (int i = 0; i < 4; i++) begin
      clearDrain();
      applyStimulus(i, 32'((i + 1) * 10));
      tick();
      if (i > 0) checkHead($sformatf("skew%0d", i - 1), 32'(i * 10), i - 1, 1'b0);
    end
    clearDrain();
    tick();
    checkHead("skew3", 32'd40, 3, 1'b1);
    tick();
    checkOutput("skew_empty", 32'(res_valid_o), 32'd0);

    // Simultaneous pulses leave lowest column first.
    applyStimulus(3, 32'd7);
    applyStimulus(1, 32'd8);
    applyStimulus(0, 32'd9);
    tick();
    clearDrain();
    tick();
    checkHead("simul_c0", 32'd9, 0, 1'b0);
    tick();
    checkHead("simul_c1", 32'd8, 1, 1'b0);
    tick();
    checkHead("simul_c3", 32'd7, 3, 1'b1);
    tick();
    checkOutput("simul_empty", 32'(res_valid_o), 32'd0);
    checkOutput("simul_ovf", 32'(overflow_o), 32'd0);

    // Backpressure: 8 in the FIFO, 4 held in slots.
    res_ready_i = 1'b0;
    for (int i = 0; i < 12; i++) begin
      clearDrain();
      applyStimulus(i % 4, 32'(100 + i));
      tick();
    end
    clearDrain();
    tick();
    tick();
    checkHead("bp_hold", 32'd100, 0, 1'b0);
    checkOutput("bp_ovf", 32'(overflow_o), 32'd0);
    res_ready_i = 1'b1;
    for (int i = 0; i < 12; i++) begin
      checkHead($sformatf("bp%0d", i), 32'(100 + i), i % 4, (i % 4) == 3);
      tick();
    end
    checkOutput("bp_empty", 32'(res_valid_o), 32'd0);
    checkOutput("bp_ovf_end", 32'(overflow_o), 32'd0);

    // Collision: fill the FIFO, then hit busy slot 1 twice.
    res_ready_i = 1'b0;
    for (int i = 0; i < 8; i++) begin
      clearDrain();
      applyStimulus(0, 32'(200 + i));
      tick();
    end
    clearDrain();
    tick();
    tick();
    applyStimulus(1, 32'h0000_00AA);
    tick();
    clearDrain();
    checkOutput("coll_ovf_pre", 32'(overflow_o), 32'd0);
    tick();
    applyStimulus(1, 32'h0000_00BB);
    tick();
    clearDrain();
    tick();
    checkOutput("coll_ovf", 32'(overflow_o), 32'd1);
    res_ready_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      checkHead($sformatf("coll_fill%0d", i), 32'(200 + i), 0, 1'b0);
      tick();
    end
    checkHead("coll_aa", 32'h0000_00AA, 1, 1'b0);
    tick();
    checkOutput("coll_no_bb", 32'(res_valid_o), 32'd0);
    checkOutput("coll_ovf_sticky", 32'(overflow_o), 32'd1);

    // Mid-stream reset with 5 queued entries and a pulse in the reset cycle.
    res_ready_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      clearDrain();
      applyStimulus(i % 4, 32'(50 + i));
      tick();
    end
    clearDrain();
    tick();
    checkHead("rst2_queued", 32'd50, 0, 1'b0);
    rst_i = 1'b1;
    applyStimulus(2, 32'h0000_0077);
    tick();
    rst_i = 1'b0;
    clearDrain();
    checkOutput("rst2_valid", 32'(res_valid_o), 32'd0);
    checkOutput("rst2_ovf", 32'(overflow_o), 32'd0);
    checkOutput("rst2_data", res_data_o, 32'd0);
    tick();
    tick();
    checkOutput("rst2_pulse_ignored", 32'(res_valid_o), 32'd0);
    res_ready_i = 1'b1;
    applyStimulus(1, 32'h0000_0033);
    tick();
    clearDrain();
    tick();
    checkHead("rst2_new", 32'h33, 1, 1'b0);
    tick();
    checkOutput("rst2_end", 32'(res_valid_o), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
